pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the five-stage pipeline.
- Drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC-hold signal.
- Resolves load-use hazards, EX-stage redirects, multi-cycle instruction/data memory waits and processor halt, and counts stall cycles for performance visibility.

---
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer with stall-cycle counter
module pipe_hazard_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_done,
  input  logic             wb_halt,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             redirect_pending_q, redirect_pending_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             load_use;
  logic             dmem_stall;

  always_comb begin
    load_use   = ex_memread && ex_regwrite &&
                 ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));
    dmem_stall = (state_q == DWAIT) || ((state_q == RUN) && dmem_req && !dmem_done);
  end

  always_comb begin
    pc_stall           = 1'b0;
    if_id_stall        = 1'b0;
    if_id_flush        = 1'b0;
    id_ex_stall        = 1'b0;
    id_ex_flush        = 1'b0;
    ex_mem_stall       = 1'b0;
    mem_wb_flush       = 1'b0;
    halted             = 1'b0;
    redirect_pending_d = redirect_pending_q;

    if (state_q == HALTED) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
      halted       = 1'b1;
    end else if (dmem_stall) begin
      // EX is frozen, so a redirect here is simply re-presented after the wait
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (!imem_ready) redirect_pending_d = 1'b1;
    end else if (!imem_ready) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
    end else if (redirect_pending_q) begin
      // fetch that was in flight at redirect time returns a wrong-path word
      if_id_flush        = 1'b1;
      redirect_pending_d = 1'b0;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (wb_halt)                     state_d = HALTED;
        else if (dmem_req && !dmem_done) state_d = DWAIT;
      end
      DWAIT: begin
        if (dmem_done) state_d = wb_halt ? HALTED : RUN;
      end
      default: state_d = HALTED;
    endcase

    stall_cycles_d = stall_cycles_q;
    if (pc_stall && (state_q != HALTED) && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= RUN;
      redirect_pending_q <= 1'b0;
      stall_cycles_q     <= '0;
    end else begin
      state_q            <= state_d;
      redirect_pending_q <= redirect_pending_d;
      stall_cycles_q     <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 3;
  localparam int CNT_W = 4;

  localparam logic [7:0] PC  = 8'h80;
  localparam logic [7:0] IFS = 8'h40;
  localparam logic [7:0] IFF = 8'h20;
  localparam logic [7:0] IDS = 8'h10;
  localparam logic [7:0] IDF = 8'h08;
  localparam logic [7:0] EXS = 8'h04;
  localparam logic [7:0] MWF = 8'h02;
  localparam logic [7:0] HLT = 8'h01;
  localparam logic [7:0] FRZ = PC | IFS | IDS | EXS | MWF;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic id_rs_used, id_rt_used, ex_memread, ex_regwrite, ex_redirect;
  logic imem_ready, dmem_req, dmem_done, wb_halt;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_flush, halted;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct packed {
    logic [7:0]       o;
    logic [CNT_W-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [CNT_W-1:0] exp_cnt;
  event chk_ev;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready), .dmem_req(dmem_req),
    .dmem_done(dmem_done), .wb_halt(wb_halt),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush), .halted(halted), .stall_cycles(stall_cycles)
  );

  initial begin
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [7:0] act;
        e   = exp_q.pop_front();
        act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
               id_ex_flush, ex_mem_stall, mem_wb_flush, halted};
        n_checks++;
        if (act !== e.o) begin
          n_errors++;
          $display("FAIL outputs @%0t: got %b want %b (pc,ifs,iff,ids,idf,exs,mwf,hlt)",
                   $time, act, e.o);
        end
        n_checks++;
        if (stall_cycles !== e.c) begin
          n_errors++;
          $display("FAIL stall_cycles @%0t: got %0d want %0d", $time, stall_cycles, e.c);
        end
      end
    end
  end

  task automatic idle();
    id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    ex_rd = '0; ex_memread = 1'b0; ex_regwrite = 1'b0; ex_redirect = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_done = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic step(input logic [7:0] o);
    exp_t e;
    e.o = o;
    e.c = exp_cnt;
    exp_q.push_back(e);
    if (o[7] && !o[0] && !(&exp_cnt)) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    exp_cnt = '0;
    step(8'h00);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_cnt = '0;
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    step(8'h00);

    // load-use on rs, then forwarding covers it
    ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1;
    step(PC | IFS | IDF);
    idle();
    step(8'h00);
    // rs matches but is unused; load without regwrite
    ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rs = 3; id_rs_used = 0;
    step(8'h00);
    ex_regwrite = 0; id_rs_used = 1;
    step(8'h00);
    // rt match on register zero still stalls
    idle();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rt = 0; id_rt_used = 1;
    step(PC | IFS | IDF);
    idle();

    // redirect with fetch ready: no pending flag afterwards
    ex_redirect = 1;
    step(IFF | IDF);
    idle();
    step(8'h00);

    // redirect during fetch miss
    ex_redirect = 1; imem_ready = 0;
    step(IFF | IDF);
    ex_redirect = 0;
    step(PC | IFF);
    step(PC | IFF);
    imem_ready = 1;
    step(IFF);
    step(8'h00);

    // second redirect while pending keeps the flag
    ex_redirect = 1; imem_ready = 0;
    step(IFF | IDF);
    step(IFF | IDF);
    ex_redirect = 0; imem_ready = 1;
    step(IFF);
    step(8'h00);

    // single-cycle data access
    dmem_req = 1; dmem_done = 1;
    step(8'h00);

    // data wait with load-use and redirect presented
    do_reset();
    dmem_req = 1; dmem_done = 0; ex_redirect = 1;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1;
    step(FRZ);
    step(FRZ);
    step(FRZ);
    dmem_done = 1;
    step(FRZ);
    idle();
    step(8'h00);

    // halt, then asynchronous reset mid-cycle
    wb_halt = 1;
    step(8'h00);
    wb_halt = 0; imem_ready = 0;
    step(FRZ | HLT);
    step(FRZ | HLT);
    idle();
    #2;
    rst = 1'b0;
    #1;
    begin
      exp_t e;
      e.o = 8'h00;
      e.c = '0;
      exp_q.push_back(e);
    end
    ->chk_ev;
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(8'h00);

    // saturation of the stall counter
    do_reset();
    imem_ready = 0;
    for (int i = 0; i < 20; i++) step(PC | IFF);
    idle();
    step(8'h00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
